// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg: shared types for the SD SPI read-port arbiter.
// FSM state encoding, requester index type and requester limit.
package sd_arb_pkg;

  localparam int MAX_REQ = 4;

  typedef logic [1:0] req_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    OWNED,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/sd_spi_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports: eligible mask, rr_ptr in; found flag and winning idx out.
module rr_pick
  import sd_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] eligible,
  input  req_idx_t     rr_ptr,
  output logic         found,
  output req_idx_t     idx
);

  logic [N-1:0] rot;

  // Rotate so bit 0 is the requester at rr_ptr.
  assign rot = N'({eligible, eligible} >> rr_ptr);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        idx   = req_idx_t'((int'(rr_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/sd_spi_arbiter.sv
// sd_spi_arbiter: shares one SD SPI read port between N_REQ requesters.
// Ports: clk, reset (async low), req_* in, gnt/req_busy/req_err/
// req_data_out/timeout_irq out, spi_* to/from the SD controller.
module sd_spi_arbiter
  import sd_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_r_multi_block,
  input  logic [N_REQ-1:0]     req_r_byte,
  input  logic [N_REQ*32-1:0]  req_block_addr,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     req_busy,
  output logic [N_REQ-1:0]     req_err,
  output logic [7:0]           req_data_out,
  output logic                 timeout_irq,
  output logic                 spi_r_multi_block,
  output logic                 spi_r_byte,
  output logic [31:0]          spi_block_addr,
  input  logic                 spi_busy,
  input  logic                 spi_err,
  input  logic [7:0]           spi_data_out
);

  localparam int WD_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam req_idx_t OWN_LAST = req_idx_t'(N_REQ - 1);

  arb_state_t       state;
  req_idx_t         owner;
  req_idx_t         rr_ptr;
  logic [N_REQ-1:0] revoked;
  logic [WD_W-1:0]  wd;
  logic [7:0]       gap;
  logic [N_REQ-1:0] gnt_q;
  logic             irq_q;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] own_oh;
  logic [N_REQ-1:0] pick_oh;
  logic             pick_found;
  req_idx_t         pick_idx;
  logic             owned;
  logic             owner_valid;
  logic             revoke_now;
  logic [31:0]      addr_mux;

  assign eligible = req_valid & ~revoked;

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_comb begin
    own_oh   = '0;
    pick_oh  = '0;
    addr_mux = '0;
    for (int i = 0; i < N_REQ; i++) begin
      own_oh[i]  = (owner == req_idx_t'(i));
      pick_oh[i] = (pick_idx == req_idx_t'(i));
      if (owner == req_idx_t'(i))
        addr_mux = req_block_addr[i*32 +: 32];
    end
  end

  assign owned       = (state == OWNED);
  assign owner_valid = |(req_valid & own_oh);
  assign revoke_now  = owned && owner_valid &&
                       spi_busy && (wd == WD_LAST);

  // Outputs are gated by the registered state, so an async
  // reset drops them without waiting for a clock.
  assign spi_r_multi_block =
    owned & |(req_r_multi_block & own_oh);
  assign spi_r_byte = owned & |(req_r_byte & own_oh);
  assign spi_block_addr = owned ? addr_mux : 32'h0;

  assign req_busy = owned ?
    (~own_oh | (spi_busy ? own_oh : '0)) : '1;
  assign req_err = (owned && spi_err) ? own_oh : '0;
  assign req_data_out = spi_data_out;
  assign gnt = gnt_q;
  assign timeout_irq = irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      revoked <= '0;
      wd      <= '0;
      gap     <= '0;
      gnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      irq_q   <= 1'b0;
      // A revoked requester is forgiven once it lets go.
      revoked <= (revoked & req_valid) |
                 (revoke_now ? own_oh : '0);
      unique case (state)
        IDLE: begin
          if (|eligible)
            state <= ARB;
        end
        ARB: begin
          if (pick_found) begin
            owner  <= pick_idx;
            gnt_q  <= pick_oh;
            rr_ptr <= (pick_idx == OWN_LAST) ?
                      '0 : req_idx_t'(pick_idx + 1'b1);
            wd     <= '0;
            state  <= OWNED;
          end else begin
            state <= IDLE;
          end
        end
        OWNED: begin
          if (!owner_valid || revoke_now) begin
            state <= RELEASE;
            gnt_q <= '0;
            gap   <= '0;
            wd    <= '0;
            irq_q <= revoke_now;
          end else if (!spi_busy) begin
            wd <= '0;
          end else if (wd != '1) begin
            wd <= wd + 1'b1;
          end
        end
        RELEASE: begin
          if (gap >= GAP_LAST && !spi_busy)
            state <= ARB;
          else if (gap != 8'hFF)
            gap <= gap + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// tb_sd_spi_arbiter: directed self-checking bench for sd_spi_arbiter.
// N_REQ=2, GAP_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_sd_spi_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_r_multi_block;
  logic [1:0]  req_r_byte;
  logic [63:0] req_block_addr;
  logic [1:0]  gnt;
  logic [1:0]  req_busy;
  logic [1:0]  req_err;
  logic [7:0]  req_data_out;
  logic        timeout_irq;
  logic        spi_r_multi_block;
  logic        spi_r_byte;
  logic [31:0] spi_block_addr;
  logic        spi_busy;
  logic        spi_err;
  logic [7:0]  spi_data_out;

  int vectors = 0;
  int miscompares = 0;

  sd_spi_arbiter #(
    .N_REQ          (2),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_r_multi_block (req_r_multi_block),
    .req_r_byte        (req_r_byte),
    .req_block_addr    (req_block_addr),
    .gnt               (gnt),
    .req_busy          (req_busy),
    .req_err           (req_err),
    .req_data_out      (req_data_out),
    .timeout_irq       (timeout_irq),
    .spi_r_multi_block (spi_r_multi_block),
    .spi_r_byte        (spi_r_byte),
    .spi_block_addr    (spi_block_addr),
    .spi_busy          (spi_busy),
    .spi_err           (spi_err),
    .spi_data_out      (spi_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int lim, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt == 2'b00 && n < lim);
  endtask

  initial begin
    int n;
    logic [1:0] cur;
    logic [1:0] exp_g [4];
    logic seen;

    exp_g[0] = 2'b01;
    exp_g[1] = 2'b10;
    exp_g[2] = 2'b01;
    exp_g[3] = 2'b10;

    reset = 1'b0;
    req_valid = '0;
    req_r_multi_block = '0;
    req_r_byte = '0;
    req_block_addr = '0;
    spi_busy = 1'b0;
    spi_err = 1'b0;
    spi_data_out = '0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(req_busy), 32'h3);
    chk("rst_err", 32'(req_err), 32'h0);
    chk("rst_mb", 32'(spi_r_multi_block), 32'h0);
    chk("rst_addr", spi_block_addr, 32'h0);
    chk("rst_irq", 32'(timeout_irq), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (9) tick();

    // single requester
    req_block_addr = {32'hBEEF_0002, 32'h0000_1234};
    req_r_multi_block = 2'b01;
    req_valid = 2'b01;
    wait_gnt(10, n);
    chk("single_lat", 32'(n), 32'd2);
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_mb", 32'(spi_r_multi_block), 32'h1);
    chk("single_addr", spi_block_addr, 32'h1234);
    chk("single_busy0", 32'(req_busy), 32'h2);
    req_r_byte = 2'b01;
    #1;
    chk("single_byte", 32'(spi_r_byte), 32'h1);
    req_r_byte = 2'b00;
    spi_busy = 1'b1;
    spi_err = 1'b1;
    spi_data_out = 8'hA5;
    #1;
    chk("single_busy1", 32'(req_busy), 32'h3);
    chk("single_err", 32'(req_err), 32'h1);
    chk("data_bcast", 32'(req_data_out), 32'hA5);
    spi_err = 1'b0;
    tick();

    // release while card still busy; requester 1 waits
    req_r_multi_block = 2'b11;
    req_valid = 2'b10;
    tick();
    chk("rel_gnt", 32'(gnt), 32'h0);
    chk("rel_mb", 32'(spi_r_multi_block), 32'h0);
    chk("rel_busy", 32'(req_busy), 32'h3);
    seen = 1'b0;
    repeat (29) begin
      tick();
      if (gnt != 2'b00) seen = 1'b1;
    end
    chk("busy_hold", 32'(seen), 32'h0);
    spi_busy = 1'b0;
    wait_gnt(20, n);
    chk("busy_lat", 32'(n), 32'd2);
    chk("busy_gnt", 32'(gnt), 32'h2);
    chk("own1_addr", spi_block_addr, 32'hBEEF_0002);
    spi_err = 1'b1;
    #1;
    chk("err_route", 32'(req_err), 32'h2);
    spi_err = 1'b0;

    // round-robin contention
    req_valid = 2'b11;
    for (int s = 0; s < 4; s++) begin
      repeat (20) tick();
      cur = gnt;
      req_valid = 2'b11 & ~cur;
      tick();
      chk("rr_drop", 32'(gnt), 32'h0);
      req_valid = 2'b11;
      wait_gnt(20, n);
      chk("rr_gap", 32'(n), 32'd5);
      chk("rr_gnt", 32'(gnt), 32'(exp_g[s]));
    end

    // watchdog revoke of requester 0
    repeat (5) tick();
    req_valid = 2'b01;
    wait_gnt(20, n);
    chk("wd_pre_lat", 32'(n), 32'd6);
    chk("wd_pre_gnt", 32'(gnt), 32'h1);
    spi_busy = 1'b1;
    req_valid = 2'b11;
    n = 0;
    do begin
      tick();
      n++;
    end while (!timeout_irq && n < 100);
    chk("wd_cycles", 32'(n), 32'd64);
    chk("wd_gnt", 32'(gnt), 32'h0);
    tick();
    chk("wd_pulse", 32'(timeout_irq), 32'h0);
    repeat (3) tick();
    chk("wd_wait", 32'(gnt), 32'h0);
    spi_busy = 1'b0;
    wait_gnt(20, n);
    chk("wd_next_lat", 32'(n), 32'd2);
    chk("wd_next_gnt", 32'(gnt), 32'h2);
    req_valid = 2'b01;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (gnt != 2'b00) seen = 1'b1;
    end
    chk("revoked_hold", 32'(seen), 32'h0);
    req_valid = 2'b00;
    tick();
    req_valid = 2'b01;
    wait_gnt(20, n);
    chk("unrevoke_lat", 32'(n), 32'd2);
    chk("unrevoke_gnt", 32'(gnt), 32'h1);

    // async reset mid-session
    chk("pre_rst_mb", 32'(spi_r_multi_block), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_mb", 32'(spi_r_multi_block), 32'h0);
    chk("arst_busy", 32'(req_busy), 32'h3);
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b11;
    wait_gnt(20, n);
    chk("post_rst_gnt", 32'(gnt), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
